dmem_arbiter: RTL and testbench

Arbitrates the single-port 256x8 data memory between two requesters: the core's load/store path (port C) and the host loader port (port H) that preloads operands and reads results. Sits between the core, the host interface and the data memory instance. Core has fixed priority, with a starvation guard that forces a host grant after a bounded wait. Read data returns one cycle after grant, tagged to the owning port. A saturating conflict counter supports cycle-count analysis.

---
 rtl/dmem_arbiter_pkg.sv | 7 +
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter_sat_counter.sv | 17 +
 rtl/dmem_arbiter.sv | 50 +++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and width defaults for the data memory arbiter
package dmem_arbiter_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic {CORE_PRI, HOST_FORCE} arb_mode_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_H} owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and memory-side signals of the data memory arbiter
interface dmem_arbiter_if import dmem_arbiter_pkg::*; #(parameter int AW = AW_DEF, parameter int DW = DW_DEF);
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          h_req, h_we, h_gnt, h_rvalid;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   conflict_ct;
  modport master (
    output c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
    input  c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, conflict_ct
  );
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
    output c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, conflict_ct
  );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async reset
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment stops at all-ones
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign q_o = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority arbiter for a single-port data memory with host starvation guard
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic           CLK,
  input logic           start,
  dmem_arbiter_if.slave bus
);
  arb_mode_t  mode_q, mode_d;
  owner_t     own_q, own_d;
  logic [3:0] starve_q;
  logic       c_gnt, h_gnt, starve_inc, c_rv, h_rv;
  // grant decode: core wins unless the host is being forced through
  always_comb begin
    c_gnt      = bus.c_req && mode_q == CORE_PRI;
    h_gnt      = bus.h_req && !c_gnt;
    starve_inc = bus.h_req && !h_gnt;
    mode_d     = (mode_q == CORE_PRI && starve_q == 4'(STARVE_LIMIT) && starve_inc) ? HOST_FORCE : CORE_PRI;
    own_d      = (c_gnt && !bus.c_we) ? OWN_C : (h_gnt && !bus.h_we) ? OWN_H : OWN_NONE;
  end
  assign bus.c_gnt     = c_gnt;
  assign bus.h_gnt     = h_gnt;
  assign bus.mem_en    = c_gnt || h_gnt;
  assign bus.mem_we    = h_gnt ? bus.h_we : c_gnt && bus.c_we;
  assign bus.mem_addr  = h_gnt ? bus.h_addr : c_gnt ? bus.c_addr : {AW{1'b0}};
  assign bus.mem_wdata = h_gnt ? bus.h_wdata : c_gnt ? bus.c_wdata : {DW{1'b0}};
  // mode and read-owner registers; reset drops any pending read result
  always_ff @(posedge CLK or posedge start)
    if (start) begin
      mode_q <= CORE_PRI;
      own_q  <= OWN_NONE;
    end else begin
      mode_q <= mode_d;
      own_q  <= own_d;
    end
  assign c_rv         = own_q == OWN_C;
  assign h_rv         = own_q == OWN_H;
  assign bus.c_rvalid = c_rv;
  assign bus.h_rvalid = h_rv;
  assign bus.c_rdata  = c_rv ? bus.mem_rdata : {DW{1'b0}};
  assign bus.h_rdata  = h_rv ? bus.mem_rdata : {DW{1'b0}};
  sat_counter #(.W(4)) u_starve (
    .clk(CLK), .rst(start), .clr_i(!starve_inc), .inc_i(starve_inc), .q_o(starve_q)
  );
  sat_counter #(.W(16)) u_conflict (
    .clk(CLK), .rst(start), .clr_i(1'b0), .inc_i(bus.c_req && bus.h_req), .q_o(bus.conflict_ct)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  logic CLK = 1'b0;
  logic start;
  int vectors = 0, errors = 0;
  dmem_arbiter_if #(.AW(8), .DW(8)) bus();
  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(8), .DW(8)) dut (.CLK(CLK), .start(start), .bus(bus));
  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  logic [7:0] rd_q;
  always @(posedge CLK)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr];
    end
  assign bus.mem_rdata = rd_q;

  logic [7:0] shadow [256];
  logic [7:0] m_pdata;
  bit m_forced;
  int m_wait, m_pend, m_conf;

  function automatic logic gc();
    return bus.c_req && !m_forced;
  endfunction
  function automatic logic gh();
    return bus.h_req && !gc();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge start)
    if (start) begin
      m_forced <= 1'b0;
      m_wait   <= 0;
      m_pend   <= 0;
      m_conf   <= 0;
    end else begin
      m_pend  <= (gc() && !bus.c_we) ? 1 : (gh() && !bus.h_we) ? 2 : 0;
      m_pdata <= gc() ? shadow[bus.c_addr] : shadow[bus.h_addr];
      if (gc() && bus.c_we) shadow[bus.c_addr] <= bus.c_wdata;
      if (gh() && bus.h_we) shadow[bus.h_addr] <= bus.h_wdata;
      if (bus.c_req && bus.h_req && m_conf < 65535) m_conf <= m_conf + 1;
      m_forced <= !m_forced && m_wait == LIMIT && bus.h_req && !gh();
      m_wait   <= (bus.h_req && !gh()) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
    end

  always @(negedge CLK)
    if (!start) begin
      chk("c_gnt", 32'(bus.c_gnt), 32'(gc()));
      chk("h_gnt", 32'(bus.h_gnt), 32'(gh()));
      chk("mem_en", 32'(bus.mem_en), 32'(gc() || gh()));
      chk("mem_we", 32'(bus.mem_we), 32'(gh() ? bus.h_we : gc() && bus.c_we));
      chk("mem_addr", 32'(bus.mem_addr), gh() ? 32'(bus.h_addr) : gc() ? 32'(bus.c_addr) : 32'd0);
      chk("mem_wdata", 32'(bus.mem_wdata), gh() ? 32'(bus.h_wdata) : gc() ? 32'(bus.c_wdata) : 32'd0);
      chk("c_rvalid", 32'(bus.c_rvalid), 32'(m_pend == 1));
      chk("h_rvalid", 32'(bus.h_rvalid), 32'(m_pend == 2));
      chk("c_rdata", 32'(bus.c_rdata), m_pend == 1 ? 32'(m_pdata) : 32'd0);
      chk("h_rdata", 32'(bus.h_rdata), m_pend == 2 ? 32'(m_pdata) : 32'd0);
      chk("conflict_ct", 32'(bus.conflict_ct), 32'(m_conf));
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic set_c(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
  endtask
  task automatic set_h(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.h_req = req; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
  endtask

  initial begin
    logic cg, hg;
    start = 1'b1;
    set_c(0, 0, 0, 0);
    set_h(0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 start = 1'b0;
    chk("reset conflict_ct", 32'(bus.conflict_ct), 32'd0);
    chk("reset c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("reset h_rdata", 32'(bus.h_rdata), 32'd0);
    for (int i = 0; i < 64; i++) begin
      set_h(1, 1, 8'(32 + i), 8'($urandom));
      @(negedge CLK);
      chk("preload h_gnt", 32'(bus.h_gnt), 32'd1);
      chk("preload mem_we", 32'(bus.mem_we), 32'd1);
      tick();
    end
    chk("preload conflict_ct", 32'(bus.conflict_ct), 32'd0);
    set_h(1, 1, 8'd9, 8'h02);
    tick();
    set_h(0, 0, 0, 0);
    set_c(1, 0, 8'd9, 8'h00);
    @(negedge CLK);
    chk("core read c_gnt", 32'(bus.c_gnt), 32'd1);
    tick();
    set_c(0, 0, 0, 0);
    @(negedge CLK);
    chk("core read c_rvalid", 32'(bus.c_rvalid), 32'd1);
    chk("core read c_rdata", 32'(bus.c_rdata), 32'h02);
    chk("core read h_rvalid", 32'(bus.h_rvalid), 32'd0);
    set_h(1, 1, 8'd10, 8'hA5);
    tick();
    set_h(1, 1, 8'd11, 8'h5A);
    tick();
    set_h(0, 0, 0, 0);
    set_c(1, 0, 8'd10, 8'h00);
    tick();
    set_c(0, 0, 0, 0);
    set_h(1, 0, 8'd11, 8'h00);
    @(negedge CLK);
    chk("alt c_rvalid", 32'(bus.c_rvalid), 32'd1);
    chk("alt c_rdata", 32'(bus.c_rdata), 32'hA5);
    tick();
    set_h(0, 0, 0, 0);
    @(negedge CLK);
    chk("alt h_rvalid", 32'(bus.h_rvalid), 32'd1);
    chk("alt h_rdata", 32'(bus.h_rdata), 32'h5A);
    chk("alt c_rvalid low", 32'(bus.c_rvalid), 32'd0);
    tick();
    set_c(1, 0, 8'd40, 8'h00);
    set_h(1, 0, 8'd41, 8'h00);
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge CLK);
      chk("starve h_gnt", 32'(bus.h_gnt), 32'(cyc == 5));
      chk("starve c_gnt", 32'(bus.c_gnt), 32'(cyc != 5));
      if (cyc == 6) chk("starve conflict_ct", 32'(bus.conflict_ct), 32'd6);
      tick();
      if (cyc == 5) set_h(0, 0, 0, 0);
    end
    set_c(0, 0, 0, 0);
    set_h(1, 0, 8'd11, 8'h00);
    tick();
    set_h(0, 0, 0, 0);
    chk("pre-reset h_rvalid", 32'(bus.h_rvalid), 32'd1);
    chk("pre-reset h_rdata", 32'(bus.h_rdata), 32'h5A);
    start = 1'b1;
    #1;
    chk("reset h_rvalid", 32'(bus.h_rvalid), 32'd0);
    chk("reset h_rdata", 32'(bus.h_rdata), 32'd0);
    chk("reset conflict", 32'(bus.conflict_ct), 32'd0);
    tick();
    start = 1'b0;
    @(negedge CLK);
    chk("discarded h_rvalid", 32'(bus.h_rvalid), 32'd0);
    tick();
    set_c(1, 0, 8'd40, 8'h00);
    set_h(1, 0, 8'd41, 8'h00);
    @(negedge CLK);
    chk("post-reset c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("post-reset h_gnt", 32'(bus.h_gnt), 32'd0);
    tick();
    set_c(0, 0, 0, 0);
    set_h(0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      cg = bus.c_gnt;
      hg = bus.h_gnt;
      tick();
      if (!bus.c_req || cg)
        set_c(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), 8'(32 + $urandom_range(0, 15)), 8'($urandom));
      if (!bus.h_req || hg)
        set_h(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 8'(32 + $urandom_range(0, 15)), 8'($urandom));
    end
    set_c(1, 1, 8'd50, 8'h11);
    set_h(1, 1, 8'd51, 8'h22);
    repeat (70000) tick();
    @(negedge CLK);
    chk("saturated conflict_ct", 32'(bus.conflict_ct), 32'hFFFF);
    tick();
    set_c(0, 0, 0, 0);
    set_h(0, 0, 0, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
